dmem_arbiter: RTL and testbench

- Shares the single-port synchronous data memory (dmem) between two requesters.
  - Port 0: the PCPU load/store path.
  - Port 1: a monitor/debug master, e.g. a memory viewer feeding the 7-segment display or a loader.
- Grants at most one access per clock and returns read data one cycle later, tagged to the owner.
- Sits between PCPU/monitor and dmem, on the same clock as dmem.

---
 rtl/dmem_arb_pkg.sv | 21 ++
 rtl/rr_arb2.sv | 27 ++
 rtl/dmem_arbiter.sv | 124 ++++++++++++
 tb/tb_dmem_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg
//   Shared definitions for the dmem arbiter slice.
//   - PORT_CPU / PORT_MON : requester ids used for grant and read-owner tags.
//   - AW_DEF / DW_DEF     : default address / data widths of dmem.
//   - mem_req_t           : request bundle {we, addr, wdata} at default widths,
//                           for integrators wiring requesters at the default size.
package dmem_arb_pkg;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_MON = 1'b1;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 16;

  typedef struct packed {
    logic              we;
    logic [AW_DEF-1:0] addr;
    logic [DW_DEF-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
//   Purely combinational 2-way arbiter.
//   Ports:
//     req[1:0]    in   request per port (bit 0 = CPU, bit 1 = monitor)
//     prio_mode   in   1 = port 0 always wins a tie, 0 = alternate on ties
//     last_grant  in   id of the port granted most recently
//     gnt[1:0]    out  one-hot grant (all zero when nobody requests)
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       prio_mode,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      // Tie: fixed priority favours port 0, otherwise hand the slot to the
      // port that did not win last time.
      2'b11:   gnt = (prio_mode || last_grant) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares one single-port synchronous dmem between the PCPU load/store path
//   (port 0) and a monitor/debug master (port 1). At most one access is
//   granted per clock; read data comes back one cycle later to the owner.
//   Ports:
//     clock, reset          system clock; synchronous active-low reset
//     prio_mode             0 = round-robin on ties, 1 = port 0 fixed priority
//     m{0,1}_req/we/addr/wdata   requester access (req held until gnt)
//     m{0,1}_gnt            access accepted this cycle
//     m{0,1}_rvalid/rdata   read return, one cycle after a read grant
//     mem_addr/we/wdata     muxed request towards dmem
//     mem_rdata             dmem read data (registered inside dmem)
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          prio_mode,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  logic [1:0]    req_v;
  logic [1:0]    we_v;
  logic [AW-1:0] addr_v  [2];
  logic [DW-1:0] wdata_v [2];
  logic [1:0]    gnt_arb;
  logic [1:0]    gnt_v;
  logic          any_gnt;
  logic          sel;

  logic          last_grant_reg;
  logic          rd_pend_reg;
  logic          rd_owner_reg;

  logic [1:0]    rvalid_v;
  logic [DW-1:0] rdata_v [2];

  assign req_v      = {m1_req, m0_req};
  assign we_v       = {m1_we, m0_we};
  assign addr_v[0]  = m0_addr;
  assign addr_v[1]  = m1_addr;
  assign wdata_v[0] = m0_wdata;
  assign wdata_v[1] = m1_wdata;

  rr_arb2 u_arb (
    .req        (req_v),
    .prio_mode  (prio_mode),
    .last_grant (last_grant_reg),
    .gnt        (gnt_arb)
  );

  // Nothing may reach dmem while reset is held low.
  assign gnt_v   = reset ? gnt_arb : 2'b00;
  assign any_gnt = |gnt_v;
  assign m0_gnt  = gnt_v[0];
  assign m1_gnt  = gnt_v[1];

  // With no grant the selector falls back to port 0, so mem_addr shows the
  // CPU address while idle.
  assign sel       = gnt_v[1] ? PORT_MON : PORT_CPU;
  assign mem_addr  = addr_v[sel];
  assign mem_wdata = wdata_v[sel];
  assign mem_we    = any_gnt & we_v[sel];

  always_ff @(posedge clock) begin
    if (!reset) begin
      last_grant_reg <= PORT_MON;  // port 0 wins the first tie
      rd_pend_reg    <= 1'b0;      // any read in flight is dropped
      rd_owner_reg   <= PORT_CPU;
    end else begin
      rd_pend_reg <= any_gnt & ~we_v[sel];
      if (any_gnt) begin
        last_grant_reg <= sel;
        rd_owner_reg   <= sel;
      end
    end
  end

  // Per-port read return: pass dmem data straight through in the return
  // cycle and keep a copy so rdata holds steady afterwards.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
      localparam logic PORT_ID = (gi != 0);
      logic [DW-1:0] rdata_reg;

      assign rvalid_v[gi] = reset & rd_pend_reg & (rd_owner_reg == PORT_ID);
      assign rdata_v[gi]  = rvalid_v[gi] ? mem_rdata : rdata_reg;

      always_ff @(posedge clock) begin
        if (!reset) begin
          rdata_reg <= '0;
        end else if (rvalid_v[gi]) begin
          rdata_reg <= mem_rdata;
        end
      end
    end
  endgenerate

  assign m0_rvalid = rvalid_v[0];
  assign m1_rvalid = rvalid_v[1];
  assign m0_rdata  = rdata_v[0];
  assign m1_rdata  = rdata_v[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Directed bench for dmem_arbiter with a write-first synchronous dmem model.
//   Inputs change 1 time unit after the rising edge; outputs are sampled a
//   further unit later, well away from the active edge.
module tb_dmem_arbiter;

  localparam int AW = 8;
  localparam int DW = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          prio_mode;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [2**AW];

  always #5 clock = ~clock;

  // Write-first single-port synchronous RAM.
  always @(posedge clock) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      mem_rdata     <= mem_wdata;
    end else begin
      mem_rdata <= mem[mem_addr];
    end
  end

  dmem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clock     (clock),
    .reset     (reset),
    .prio_mode (prio_mode),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_gnt    (m0_gnt),
    .m0_rvalid (m0_rvalid),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_gnt    (m1_gnt),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  task automatic tick();
    $display("txn t=%0t rst=%b g0=%b g1=%b we=%b addr=%h wd=%h rv0=%b rd0=%h rv1=%b rd1=%h",
             $time, reset, m0_gnt, m1_gnt, mem_we, mem_addr, mem_wdata,
             m0_rvalid, m0_rdata, m1_rvalid, m1_rdata);
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; prio_mode = 1'b0;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 8'h33; m0_wdata = 16'hDEAD;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 8'h44; m1_wdata = 16'hBEAD;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (m0_gnt !== 1'b0) begin errors++; $display("FAIL rst_g0 got %b exp 0", m0_gnt); end
      checks++; if (m1_gnt !== 1'b0) begin errors++; $display("FAIL rst_g1 got %b exp 0", m1_gnt); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_we got %b exp 0", mem_we); end
      tick();
    end
    m0_req = 1'b0; m1_req = 1'b0; m0_we = 1'b0; m1_we = 1'b0;
    reset = 1'b1;
    #1;
    checks++; if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin errors++; $display("FAIL post_rst_rvalid got %b%b exp 00", m1_rvalid, m0_rvalid); end
    checks++; if (m0_rdata !== 16'h0 || m1_rdata !== 16'h0) begin errors++; $display("FAIL post_rst_rdata got %h/%h exp 0000/0000", m0_rdata, m1_rdata); end
    checks++; if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL idle_gnt got %b%b we %b exp 00 we 0", m1_gnt, m0_gnt, mem_we); end
    tick();
    checks++; if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin errors++; $display("FAIL idle_rvalid got %b%b exp 00", m1_rvalid, m0_rvalid); end
  endtask

  task automatic test_write_read();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 8'h10; m0_wdata = 16'hBEEF;
    #1;
    checks++; if (m0_gnt !== 1'b1) begin errors++; $display("FAIL wr_g0 got %b exp 1", m0_gnt); end
    checks++; if (mem_we !== 1'b1 || mem_addr !== 8'h10 || mem_wdata !== 16'hBEEF) begin errors++; $display("FAIL wr_bus got we %b a %h d %h exp 1 10 beef", mem_we, mem_addr, mem_wdata); end
    tick();
    m0_we = 1'b0;
    #1;
    checks++; if (m0_gnt !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL rd_g0 got g %b we %b exp 1 0", m0_gnt, mem_we); end
    checks++; if (m0_rvalid !== 1'b0) begin errors++; $display("FAIL wr_no_rvalid got %b exp 0", m0_rvalid); end
    tick();
    m0_req = 1'b0;
    #1;
    checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== 16'hBEEF) begin errors++; $display("FAIL rd_ret got v %b d %h exp 1 beef", m0_rvalid, m0_rdata); end
    checks++; if (m1_rvalid !== 1'b0) begin errors++; $display("FAIL rd_other got %b exp 0", m1_rvalid); end
    tick();
  endtask

  task automatic test_round_robin();
    // Preload the two words through the arbiter itself.
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 8'h01; m0_wdata = 16'h1111;
    tick();
    m0_req = 1'b0; m0_we = 1'b0;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 8'h02; m1_wdata = 16'h2222;
    tick();
    m1_req = 1'b0; m1_we = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1; prio_mode = 1'b0;
    m0_req = 1'b1; m1_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (m0_gnt !== ((i % 2) == 0) || m1_gnt !== ((i % 2) == 1)) begin errors++; $display("FAIL rr_gnt%0d got %b%b exp %b%b", i, m1_gnt, m0_gnt, (i % 2) == 1, (i % 2) == 0); end
      if (i == 0) begin
        checks++; if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin errors++; $display("FAIL rr_rv0 got %b%b exp 00", m1_rvalid, m0_rvalid); end
      end else if ((i % 2) == 1) begin
        checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== 16'h1111 || m1_rvalid !== 1'b0) begin errors++; $display("FAIL rr_ret%0d got v %b%b d0 %h exp 01 1111", i, m1_rvalid, m0_rvalid, m0_rdata); end
      end else begin
        checks++; if (m1_rvalid !== 1'b1 || m1_rdata !== 16'h2222 || m0_rvalid !== 1'b0 || m0_rdata !== 16'h1111) begin errors++; $display("FAIL rr_ret%0d got v %b%b d1 %h d0 %h exp 10 2222 1111", i, m1_rvalid, m0_rvalid, m1_rdata, m0_rdata); end
      end
      tick();
    end
    m0_req = 1'b0; m1_req = 1'b0;
    #1;
    checks++; if (m1_rvalid !== 1'b1 || m1_rdata !== 16'h2222 || m0_rvalid !== 1'b0 || m0_rdata !== 16'h1111) begin errors++; $display("FAIL rr_last got v %b%b d1 %h d0 %h exp 10 2222 1111", m1_rvalid, m0_rvalid, m1_rdata, m0_rdata); end
    tick();
  endtask

  task automatic test_fixed_prio();
    prio_mode = 1'b1;
    m0_req = 1'b1; m0_addr = 8'h01; m1_req = 1'b1; m1_addr = 8'h02;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin errors++; $display("FAIL prio_gnt%0d got %b%b exp 01", i, m1_gnt, m0_gnt); end
      tick();
    end
    m0_req = 1'b0;
    #1;
    checks++; if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0) begin errors++; $display("FAIL prio_drop got %b%b exp 10", m1_gnt, m0_gnt); end
    checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== 16'h1111) begin errors++; $display("FAIL prio_ret0 got v %b d %h exp 1 1111", m0_rvalid, m0_rdata); end
    tick();
    m1_req = 1'b0;
    #1;
    checks++; if (m1_rvalid !== 1'b1 || m1_rdata !== 16'h2222) begin errors++; $display("FAIL prio_ret1 got v %b d %h exp 1 2222", m1_rvalid, m1_rdata); end
    prio_mode = 1'b0;
    tick();
  endtask

  task automatic test_mon_write();
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 8'h20; m1_wdata = 16'h1234;
    #1;
    checks++; if (m1_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 8'h20 || mem_wdata !== 16'h1234) begin errors++; $display("FAIL mwr_bus got g %b we %b a %h d %h exp 1 1 20 1234", m1_gnt, mem_we, mem_addr, mem_wdata); end
    tick();
    m1_req = 1'b0; m1_we = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 8'h20;
    #1;
    checks++; if (m0_gnt !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'h20) begin errors++; $display("FAIL mrd_bus got g %b we %b a %h exp 1 0 20", m0_gnt, mem_we, mem_addr); end
    tick();
    m0_req = 1'b0;
    #1;
    checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== 16'h1234 || m1_rvalid !== 1'b0) begin errors++; $display("FAIL mrd_ret got v %b%b d %h exp 01 1234", m1_rvalid, m0_rvalid, m0_rdata); end
    tick();
  endtask

  task automatic test_reset_drop();
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 8'h02;
    #1;
    checks++; if (m1_gnt !== 1'b1) begin errors++; $display("FAIL drop_g1 got %b exp 1", m1_gnt); end
    tick();
    m1_req = 1'b0; reset = 1'b0;
    #1;
    checks++; if (m1_rvalid !== 1'b0) begin errors++; $display("FAIL drop_rv_rst got %b exp 0", m1_rvalid); end
    tick();
    reset = 1'b1;
    #1;
    checks++; if (m1_rvalid !== 1'b0 || m1_rdata !== 16'h0) begin errors++; $display("FAIL drop_rv_post got v %b d %h exp 0 0000", m1_rvalid, m1_rdata); end
    m0_req = 1'b1; m0_addr = 8'h01; m1_req = 1'b1;
    #1;
    checks++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin errors++; $display("FAIL drop_tie got %b%b exp 01", m1_gnt, m0_gnt); end
    tick();
    m0_req = 1'b0; m1_req = 1'b0;
    #1;
    checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== 16'h1111 || m1_rvalid !== 1'b0) begin errors++; $display("FAIL drop_ret got v %b%b d %h exp 01 1111", m1_rvalid, m0_rvalid, m0_rdata); end
    tick();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_round_robin();
    test_fixed_prio();
    test_mon_write();
    test_reset_drop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
